// File: rtl/upd7800_clkgen_pkg.sv
// Shared types and helpers for the uPD7800 two-phase clock generator.
package upd7800_clkgen_pkg;

    typedef enum logic [1:0] {
        CQ_P1 = 2'd0,
        CQ_G1 = 2'd1,
        CQ_P2 = 2'd2,
        CQ_G2 = 2'd3
    } e_cq;

    typedef enum logic [0:0] {
        CGST_RUN  = 1'b0,
        CGST_HOLD = 1'b1
    } e_cgst;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/upd7800_clkgen_sync2.sv
// Two-flop synchroniser with asynchronous active-low clear.
module upd7800_clkgen_sync2 (
    input  logic CLK,
    input  logic clr_n,
    input  logic d,
    output logic q
);

    logic s0;

    always_ff @(posedge CLK or negedge clr_n) begin
        if (!clr_n) begin
            s0 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s0 <= d;
            q  <= s0;
        end
    end

endmodule

// File: rtl/upd7800_clkgen.sv
// uPD7800 two-phase strobe generator with CPU reset stretch and a
// cycle-boundary bus-hold handshake.
module upd7800_clkgen
    import upd7800_clkgen_pkg::*;
#(
    parameter int unsigned DIV        = 1,
    parameter int unsigned RST_CYCLES = 16
) (
    input  logic CLK,
    input  logic RESETB,
    input  logic HOLD_REQ,
    output logic HOLD_ACK,
    output logic CP1_POSEDGE,
    output logic CP1_NEGEDGE,
    output logic CP2_POSEDGE,
    output logic CP2_NEGEDGE,
    output logic CP1,
    output logic CP2,
    output logic CPU_RESETB
);

    localparam int unsigned DW = cnt_width(DIV);
    localparam int unsigned RW = cnt_width(RST_CYCLES + 1);

    logic          rs1;
    logic [DW-1:0] dcnt, dcnt_nxt;
    e_cq           q, q_nxt;
    logic [RW-1:0] rcnt, rcnt_nxt;
    e_cgst         st, st_nxt;
    logic          cpu_resetb_nxt;
    logic          tick;
    logic          dcnt_last;
    logic          boundary;

    upd7800_clkgen_sync2 u_sync (
        .CLK   (CLK),
        .clr_n (RESETB),
        .d     (1'b1),
        .q     (rs1)
    );

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            dcnt       <= '0;
            q          <= CQ_P1;
            rcnt       <= '0;
            st         <= CGST_RUN;
            CPU_RESETB <= 1'b0;
        end else begin
            dcnt       <= dcnt_nxt;
            q          <= q_nxt;
            rcnt       <= rcnt_nxt;
            st         <= st_nxt;
            CPU_RESETB <= cpu_resetb_nxt;
        end
    end

    always_comb begin
        tick           = rs1 && (st == CGST_RUN);
        dcnt_last      = (dcnt == DW'(DIV - 1));
        boundary       = tick && dcnt_last && (q == CQ_G2);
        dcnt_nxt       = dcnt;
        q_nxt          = q;
        rcnt_nxt       = rcnt;
        st_nxt         = st;
        cpu_resetb_nxt = CPU_RESETB;

        if (tick) begin
            if (dcnt_last) begin
                dcnt_nxt = '0;
                q_nxt    = e_cq'(2'(q + 2'd1));
            end else begin
                dcnt_nxt = DW'(dcnt + DW'(1));
            end
        end

        // Reset stretch counts whole CPU cycles, then releases on that boundary.
        if (boundary && !CPU_RESETB) begin
            if (rcnt != RW'(RST_CYCLES))
                rcnt_nxt = RW'(rcnt + RW'(1));
            if (rcnt >= RW'(RST_CYCLES - 1))
                cpu_resetb_nxt = 1'b1;
        end

        case (st)
            CGST_RUN: begin
                if (boundary && HOLD_REQ && CPU_RESETB)
                    st_nxt = CGST_HOLD;
            end
            CGST_HOLD: begin
                if (!HOLD_REQ)
                    st_nxt = CGST_RUN;
            end
            default: st_nxt = CGST_RUN;
        endcase
    end

    // Everything below decodes registered state only.
    always_comb begin
        CP1_POSEDGE = tick && (dcnt == '0) && (q == CQ_P1);
        CP1_NEGEDGE = tick && (dcnt == '0) && (q == CQ_G1);
        CP2_POSEDGE = tick && (dcnt == '0) && (q == CQ_P2);
        CP2_NEGEDGE = tick && (dcnt == '0) && (q == CQ_G2);
        CP1         = tick && (q == CQ_P1);
        CP2         = tick && (q == CQ_P2);
        HOLD_ACK    = (st == CGST_HOLD);
    end

endmodule
